ioctl_loader: RTL and testbench
===============================

# ioctl_loader

Parametrised download router between the HPS/Verilator `ioctl_*` stream and up to `NUM_CH` target memories (ROM banks, tape buffer, snapshot RAM). It replaces the hardwired `ioctl_wait = 0` with real back-pressure. Incoming bytes are queued in a FIFO and drained to the selected channel under a per-channel ready handshake. Each completed download produces a done pulse and a byte count. Errors are sticky flags.

## Interface
Parameters:
- `ADDR_W`, 16: target address width; bytes at `ioctl_addr >= 2**ADDR_W` are rejected.
- `NUM_CH`, 4: number of target channels (1..8).
- `INDEX_BASE`, 0: `ioctl_index` value mapped to channel 0.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, at least 4.

Ports:
- `clk_sys`, in, 1: system clock; all logic runs on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `ioctl_download`, in, 1: download active.
- `ioctl_wr`, in, 1: one-cycle byte strobe.
- `ioctl_addr`, in, 25: byte address within the download.
- `ioctl_dout`, in, 8: byte data.
- `ioctl_index`, in, 8: download target selector.
- `ioctl_wait`, out, 1: registered back-pressure to the host.
- `mem_we`, out, NUM_CH: one-hot write strobe, one cycle per byte.
- `mem_addr`, out, ADDR_W: write address, shared by all channels.
- `mem_data`, out, 8: write data, shared by all channels.
- `mem_ready`, in, NUM_CH: channel can accept a write this cycle.
- `done`, out, NUM_CH: one-cycle pulse on the channel just loaded.
- `byte_count`, out, 25: bytes accepted in the last download; valid from the `done` pulse onward.
- `err_range`, out, 1: sticky; an index or address was out of range.
- `err_ovf`, out, 1: sticky; a write arrived while the FIFO was full.

## Operation
- Channel mapping: `ch = ioctl_index - INDEX_BASE`, computed as an 8-bit unsigned value. `ch >= NUM_CH` is out of range.
- Accept condition: `ioctl_wr` is high, state is LOAD, `ch` is in range, and `ioctl_addr[24:ADDR_W] == 0`.
  - An accepted byte pushes `{ch, ioctl_addr[ADDR_W-1:0], ioctl_dout}` into the FIFO and increments `byte_count`.
  - A byte failing only the range checks is discarded and sets `err_range`.
  - A byte arriving while the FIFO is full is discarded, sets `err_ovf`, and is not counted.
- Drain:
  - When the FIFO is non-empty and `mem_ready[head.ch]` is high, pop the head entry.
  - In that cycle drive `mem_we[head.ch] = 1`, `mem_addr`, and `mem_data`.
  - Otherwise `mem_we = 0` and the head entry stays in place.
  - Push and pop may occur in the same cycle; the FIFO count is then unchanged.
- State machine (IDLE, LOAD, FLUSH, DONE):
  - IDLE → LOAD when `ioctl_download` is 1. On this transition, clear `byte_count` and latch `ch` as the active channel.
  - LOAD → FLUSH when `ioctl_download` falls.
  - FLUSH → DONE when the FIFO is empty.
  - DONE → IDLE after exactly 1 cycle, during which `done[active ch]` is 1. If the active channel was out of range, no `done` bit fires.
  - A new `ioctl_download` rise during FLUSH or DONE is held off by `ioctl_wait` and is taken from IDLE.
- `ioctl_wait` next-state is 1 when either condition holds:
  - state is LOAD and FIFO count after this cycle's push/pop is `>= FIFO_DEPTH-1`;
  - state is FLUSH or DONE while `ioctl_download` is 1.
- Error flags clear only on reset.

## Timing
- Reset values: `ioctl_wait = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_data = 0`, `done = 0`, `byte_count = 0`, `err_range = 0`, `err_ovf = 0`, state IDLE, FIFO empty.
- Latency: a byte pushed at edge N can drive `mem_we` in cycle N+1 at the earliest, when `mem_ready` is high. With `mem_ready` held high, sustained throughput is 1 byte per clock.
- `ioctl_wait` is registered, so the host may issue one more write in the cycle wait rises. The `FIFO_DEPTH-1` threshold leaves room for that byte; overflow occurs only if the host ignores wait.
- Reset asserted mid-download immediately clears the FIFO, all outputs, and the state; no `done` is produced.
- `ioctl_wr` in the same cycle as the `ioctl_download` fall is not accepted, because state is already leaving LOAD.

## Test plan
- Basic load: index=0, bytes 0x11,0x22,0x33 at addr 0..2, `mem_ready` all 1 → `mem_we[0]` pulses at addr 0,1,2 with matching data; `done[0]` pulses once; `byte_count = 3`.
- Back-pressure: `FIFO_DEPTH=8`, `mem_ready[1]=0`, index=1, 10 writes honouring wait → `ioctl_wait` rises after the 7th push; release ready → all 10 bytes delivered in order; `err_ovf = 0`.
- Overflow: same setup but the host ignores wait → the 9th and 10th bytes are dropped; `err_ovf = 1`; `byte_count = 8`.
- Range: index=`NUM_CH`+`INDEX_BASE` → no `mem_we`, `err_range = 1`, no `done`. Separately, addr=`2**ADDR_W` on channel 0 → byte dropped, `err_range = 1`.
- Flush ordering: drop `ioctl_download` with 5 entries queued and `mem_ready` toggling 1/0 → `done[ch]` fires exactly one cycle after the last `mem_we`. A new download raised during FLUSH sees `ioctl_wait = 1` until IDLE.
- Reset mid-operation: pull `reset` low with 4 queued bytes → outputs reach their reset values asynchronously, no further `mem_we`, and `done` stays 0.

Source files
------------

// File: rtl/ioctl_loader.sv
// ioctl_loader: routes the host ioctl download byte stream into one of NUM_CH
// target memories through a small FIFO. The FIFO provides real back-pressure
// to the host through ioctl_wait.
//
// Ports
//   clk_sys          system clock, rising edge
//   reset            asynchronous, active-low reset
//   ioctl_download   host download active
//   ioctl_wr         one-cycle byte strobe from the host
//   ioctl_addr       byte address within the download (25 bit)
//   ioctl_dout       byte data from the host
//   ioctl_index      download target selector
//   ioctl_wait       registered back-pressure to the host
//   mem_we           one-hot write strobe, one cycle per byte
//   mem_addr         write address shared by all channels
//   mem_data         write data shared by all channels
//   mem_ready        per-channel ready; a write is issued only when set
//   done             one-cycle pulse on the channel just loaded
//   byte_count       bytes accepted in the last download
//   err_range        sticky: index or address out of range
//   err_ovf          sticky: write arrived while the FIFO was full
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for ioctl_download; latches channel, clears count
// S_LOAD  | accepting host bytes into the FIFO while draining it
// S_FLUSH | download ended; draining the remaining FIFO entries
// S_DONE  | one cycle; done[active channel] is high
module ioctl_loader #(
  parameter int ADDR_W     = 16,
  parameter int NUM_CH     = 4,
  parameter int INDEX_BASE = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  output logic [NUM_CH-1:0] mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic [NUM_CH-1:0] mem_ready,
  output logic [NUM_CH-1:0] done,
  output logic [24:0]       byte_count,
  output logic              err_range,
  output logic              err_ovf
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = CH_W + ADDR_W + 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          active_q, active_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [24:0]         byte_count_q, byte_count_d;
  logic                wait_q, wait_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic                err_range_q, err_range_d;
  logic                err_ovf_q, err_ovf_d;

  logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];

  logic [7:0]          ch;
  logic                ch_ok;
  logic                addr_ok;
  logic                load_wr;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [ENT_W-1:0]    push_entry;
  logic [ENT_W-1:0]    head;
  logic [CH_W-1:0]     head_ch;
  logic [ADDR_W-1:0]   head_addr;
  logic [7:0]          head_data;
  logic                head_ready;
  logic [NUM_CH-1:0]   head_onehot;

  // Channel index wraps modulo 256, so indices below INDEX_BASE land high
  // and fail the range check rather than aliasing onto a real channel.
  assign ch      = ioctl_index - 8'(INDEX_BASE);
  assign ch_ok   = (int'(ch) < NUM_CH);
  assign addr_ok = ((ioctl_addr >> ADDR_W) == 25'd0);

  // The write in the cycle download falls is ignored: state is leaving LOAD.
  assign load_wr    = ioctl_wr && (state_q == S_LOAD) && ioctl_download;
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = load_wr && ch_ok && addr_ok && !fifo_full;
  assign push_entry = {ch[CH_W-1:0], ioctl_addr[ADDR_W-1:0], ioctl_dout};

  assign head      = fifo_mem[rd_ptr_q];
  assign head_ch   = head[ENT_W-1 -: CH_W];
  assign head_addr = head[8 +: ADDR_W];
  assign head_data = head[7:0];

  always_comb begin
    head_ready  = 1'b0;
    head_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(head_ch) == i) begin
        head_ready     = mem_ready[i];
        head_onehot[i] = 1'b1;
      end
    end
  end

  assign pop = !fifo_empty && head_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    byte_count_d = byte_count_q;
    case (state_q)
      S_IDLE: begin
        if (ioctl_download) begin
          state_d      = S_LOAD;
          active_d     = ch;
          byte_count_d = '0;
        end
      end
      S_LOAD: begin
        if (push) byte_count_d = byte_count_q + 25'd1;
        if (!ioctl_download) state_d = S_FLUSH;
      end
      // Using the post-pop count lets done follow the last write by one cycle.
      S_FLUSH: begin
        if (count_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_d = '0;
    if ((state_q == S_FLUSH) && (count_d == '0)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(active_q) == i) done_d[i] = 1'b1;
      end
    end
  end

  // Threshold at DEPTH-1 leaves a slot for the write the host may issue in
  // the cycle wait rises (wait is registered).
  always_comb begin
    wait_d = ((state_q == S_LOAD) && (count_d >= CNT_W'(FIFO_DEPTH - 1))) ||
             (((state_q == S_FLUSH) || (state_q == S_DONE)) && ioctl_download);
  end

  always_comb begin
    err_range_d = err_range_q || (load_wr && !(ch_ok && addr_ok));
    err_ovf_d   = err_ovf_q   || (load_wr && ch_ok && addr_ok && fifo_full);
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      active_q     <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      byte_count_q <= '0;
      wait_q       <= 1'b0;
      done_q       <= '0;
      err_range_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      byte_count_q <= byte_count_d;
      wait_q       <= wait_d;
      done_q       <= done_d;
      err_range_q  <= err_range_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says valid.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign mem_we     = pop ? head_onehot : '0;
  assign mem_addr   = pop ? head_addr : '0;
  assign mem_data   = pop ? head_data : '0;
  assign ioctl_wait = wait_q;
  assign done       = done_q;
  assign byte_count = byte_count_q;
  assign err_range  = err_range_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_ioctl_loader.sv
module tb_ioctl_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wait;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [3:0]  mem_ready = 4'hF;
  logic [3:0]  done;
  logic [24:0] byte_count;
  logic        err_range;
  logic        err_ovf;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [3:0]  log_we[$];
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          log_cyc[$];
  int          done_cnt = 0;
  logic [3:0]  done_last = '0;
  int          done_cyc = 0;
  logic        done_wait = 1'b0;

  ioctl_loader #(.ADDR_W(16), .NUM_CH(4), .INDEX_BASE(0), .FIFO_DEPTH(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .done(done), .byte_count(byte_count), .err_range(err_range), .err_ovf(err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (mem_we != 4'h0) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data);
      log_cyc.push_back(cyc);
    end
    if (done != 4'h0) begin
      done_cnt  = done_cnt + 1;
      done_last = done;
      done_cyc  = cyc;
      done_wait = ioctl_wait;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_log();
    log_we.delete(); log_addr.delete(); log_data.delete(); log_cyc.delete();
    done_cnt = 0; done_last = '0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    step();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    step();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    step(); step();
    tests_run++; if (ioctl_wait !== 1'b0) begin tests_failed++; $display("FAIL reset_wait: got %b expected 0", ioctl_wait); end
    tests_run++; if (mem_we !== 4'h0) begin tests_failed++; $display("FAIL reset_mem_we: got %h expected 0", mem_we); end
    tests_run++; if (mem_addr !== 16'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    tests_run++; if (mem_data !== 8'h0) begin tests_failed++; $display("FAIL reset_mem_data: got %h expected 0", mem_data); end
    tests_run++; if (done !== 4'h0) begin tests_failed++; $display("FAIL reset_done: got %h expected 0", done); end
    tests_run++; if (byte_count !== 25'd0) begin tests_failed++; $display("FAIL reset_byte_count: got %0d expected 0", byte_count); end
    tests_run++; if (err_range !== 1'b0) begin tests_failed++; $display("FAIL reset_err_range: got %b expected 0", err_range); end
    tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_err_ovf: got %b expected 0", err_ovf); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3];
    int n;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    clear_log();
    mem_ready = 4'hF;
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) wr_byte(25'(i), exp_d[i]);
    end_dl();
    n = 0;
    while (done_cnt == 0 && n < 100) begin step(); n++; end
    tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL basic_done_timeout: waited %0d cycles, required done within 100", n); end
    step(); step();
    tests_run++; if (log_we.size() !== 3) begin tests_failed++; $display("FAIL basic_write_count: got %0d expected 3", log_we.size()); end
    if (log_we.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        tests_run++; if (log_we[i] !== 4'b0001) begin tests_failed++; $display("FAIL basic_we[%0d]: got %b expected 0001", i, log_we[i]); end
        tests_run++; if (log_addr[i] !== 16'(i)) begin tests_failed++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, log_addr[i], 16'(i)); end
        tests_run++; if (log_data[i] !== exp_d[i]) begin tests_failed++; $display("FAIL basic_data[%0d]: got %h expected %h", i, log_data[i], exp_d[i]); end
      end
      tests_run++; if (log_cyc[2] - log_cyc[0] !== 2) begin tests_failed++; $display("FAIL basic_throughput: got %0d cycles for 3 writes expected 2", log_cyc[2] - log_cyc[0]); end
    end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    tests_run++; if (done_last !== 4'b0001) begin tests_failed++; $display("FAIL basic_done_ch: got %b expected 0001", done_last); end
    tests_run++; if (byte_count !== 25'd3) begin tests_failed++; $display("FAIL basic_byte_count: got %0d expected 3", byte_count); end
  endtask

  task automatic test_back_pressure();
    int n;
    clear_log();
    mem_ready = 4'b1101;
    start_dl(8'd1);
    for (int k = 0; k < 7; k++) begin
      wr_byte(25'(k), 8'(8'hA0 + k));
      tests_run++;
      if (ioctl_wait !== ((k == 6) ? 1'b1 : 1'b0)) begin
        tests_failed++; $display("FAIL bp_wait_after_push%0d: got %b expected %b", k + 1, ioctl_wait, (k == 6));
      end
    end
    fork
      begin
        for (int k = 7; k < 10; k++) begin
          n = 0;
          while (ioctl_wait && n < 100) begin step(); n++; end
          tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL bp_wait_timeout: wait held %0d cycles, required release within 100", n); end
          wr_byte(25'(k), 8'(8'hA0 + k));
        end
      end
      begin
        repeat (4) step();
        mem_ready = 4'hF;
      end
    join
    end_dl();
    n = 0;
    while (done_cnt == 0 && n < 100) begin step(); n++; end
    tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL bp_done_timeout: waited %0d cycles, required done within 100", n); end
    tests_run++; if (log_we.size() !== 10) begin tests_failed++; $display("FAIL bp_write_count: got %0d expected 10", log_we.size()); end
    if (log_we.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        tests_run++;
        if (log_we[i] !== 4'b0010 || log_addr[i] !== 16'(i) || log_data[i] !== 8'(8'hA0 + i)) begin
          tests_failed++; $display("FAIL bp_entry[%0d]: got we=%b addr=%h data=%h expected we=0010 addr=%h data=%h",
                                   i, log_we[i], log_addr[i], log_data[i], 16'(i), 8'(8'hA0 + i));
        end
      end
    end
    tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL bp_err_ovf: got %b expected 0", err_ovf); end
    tests_run++; if (byte_count !== 25'd10) begin tests_failed++; $display("FAIL bp_byte_count: got %0d expected 10", byte_count); end
    tests_run++; if (done_last !== 4'b0010) begin tests_failed++; $display("FAIL bp_done_ch: got %b expected 0010", done_last); end
  endtask

  task automatic test_overflow();
    int n;
    clear_log();
    mem_ready = 4'b1101;
    start_dl(8'd1);
    for (int k = 0; k < 10; k++) wr_byte(25'(k), 8'(8'h50 + k));
    tests_run++; if (err_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", err_ovf); end
    mem_ready = 4'hF;
    end_dl();
    n = 0;
    while (done_cnt == 0 && n < 100) begin step(); n++; end
    tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL ovf_done_timeout: waited %0d cycles, required done within 100", n); end
    tests_run++; if (byte_count !== 25'd8) begin tests_failed++; $display("FAIL ovf_byte_count: got %0d expected 8", byte_count); end
    tests_run++; if (log_we.size() !== 8) begin tests_failed++; $display("FAIL ovf_write_count: got %0d expected 8", log_we.size()); end
    if (log_we.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (log_addr[i] !== 16'(i) || log_data[i] !== 8'(8'h50 + i)) begin
          tests_failed++; $display("FAIL ovf_entry[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                                   i, log_addr[i], log_data[i], 16'(i), 8'(8'h50 + i));
        end
      end
    end
    tests_run++; if (err_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", err_ovf); end
  endtask

  task automatic test_range();
    int n;
    do_reset();
    clear_log();
    mem_ready = 4'hF;
    start_dl(8'd4);
    wr_byte(25'd0, 8'h77);
    end_dl();
    repeat (10) step();
    tests_run++; if (log_we.size() !== 0) begin tests_failed++; $display("FAIL range_idx_writes: got %0d expected 0", log_we.size()); end
    tests_run++; if (err_range !== 1'b1) begin tests_failed++; $display("FAIL range_idx_err: got %b expected 1", err_range); end
    tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL range_idx_done: got %0d pulses expected 0", done_cnt); end
    tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL range_idx_ovf: got %b expected 0", err_ovf); end
    tests_run++; if (byte_count !== 25'd0) begin tests_failed++; $display("FAIL range_idx_count: got %0d expected 0", byte_count); end

    do_reset();
    clear_log();
    start_dl(8'd0);
    wr_byte(25'h10000, 8'h88);
    wr_byte(25'h0FFFF, 8'h99);
    end_dl();
    n = 0;
    while (done_cnt == 0 && n < 100) begin step(); n++; end
    tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL range_addr_done_timeout: waited %0d cycles, required done within 100", n); end
    tests_run++; if (err_range !== 1'b1) begin tests_failed++; $display("FAIL range_addr_err: got %b expected 1", err_range); end
    tests_run++; if (log_we.size() !== 1) begin tests_failed++; $display("FAIL range_addr_writes: got %0d expected 1", log_we.size()); end
    if (log_we.size() == 1) begin
      tests_run++;
      if (log_addr[0] !== 16'hFFFF || log_data[0] !== 8'h99) begin
        tests_failed++; $display("FAIL range_addr_max: got addr=%h data=%h expected addr=ffff data=99", log_addr[0], log_data[0]);
      end
    end
    tests_run++; if (byte_count !== 25'd1) begin tests_failed++; $display("FAIL range_addr_count: got %0d expected 1", byte_count); end
    tests_run++; if (done_last !== 4'b0001) begin tests_failed++; $display("FAIL range_addr_done_ch: got %b expected 0001", done_last); end
  endtask

  task automatic test_flush();
    int n;
    do_reset();
    clear_log();
    mem_ready = 4'b1011;
    start_dl(8'd2);
    for (int i = 0; i < 5; i++) wr_byte(25'(16 + i), 8'(8'hC0 + i));
    end_dl();
    fork
      begin
        for (int t = 0; t < 20; t++) begin
          mem_ready[2] = ~t[0];
          step();
        end
        mem_ready = 4'hF;
      end
      begin
        step(); step();
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        step();
        tests_run++; if (ioctl_wait !== 1'b1) begin tests_failed++; $display("FAIL flush_wait_raised: got %b expected 1", ioctl_wait); end
        n = 0;
        while (done_cnt == 0 && n < 100) begin step(); n++; end
        tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL flush_done_timeout: waited %0d cycles, required done within 100", n); end
        tests_run++; if (ioctl_wait !== 1'b1) begin tests_failed++; $display("FAIL flush_wait_idle: got %b expected 1", ioctl_wait); end
        step();
        tests_run++; if (ioctl_wait !== 1'b0) begin tests_failed++; $display("FAIL flush_wait_load: got %b expected 0", ioctl_wait); end
      end
    join
    tests_run++; if (done_wait !== 1'b1) begin tests_failed++; $display("FAIL flush_wait_at_done: got %b expected 1", done_wait); end
    tests_run++; if (log_we.size() !== 5) begin tests_failed++; $display("FAIL flush_write_count: got %0d expected 5", log_we.size()); end
    if (log_we.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (log_we[i] !== 4'b0100 || log_addr[i] !== 16'(16 + i) || log_data[i] !== 8'(8'hC0 + i)) begin
          tests_failed++; $display("FAIL flush_entry[%0d]: got we=%b addr=%h data=%h expected we=0100 addr=%h data=%h",
                                   i, log_we[i], log_addr[i], log_data[i], 16'(16 + i), 8'(8'hC0 + i));
        end
      end
      tests_run++; if (done_cyc !== log_cyc[4] + 1) begin tests_failed++; $display("FAIL flush_done_timing: got done at cycle %0d expected %0d", done_cyc, log_cyc[4] + 1); end
    end
    tests_run++; if (done_last !== 4'b0100) begin tests_failed++; $display("FAIL flush_done_ch: got %b expected 0100", done_last); end
    end_dl();
    n = 0;
    while (done_cnt < 2 && n < 100) begin step(); n++; end
    tests_run++; if (done_cnt !== 2 || done_last !== 4'b0001) begin tests_failed++; $display("FAIL flush_second_done: got count=%0d ch=%b expected count=2 ch=0001", done_cnt, done_last); end
    tests_run++; if (byte_count !== 25'd0) begin tests_failed++; $display("FAIL flush_second_count: got %0d expected 0", byte_count); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    mem_ready = 4'b0111;
    start_dl(8'd3);
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(8'hE0 + i));
    tests_run++; if (byte_count !== 25'd4) begin tests_failed++; $display("FAIL rmid_pre_count: got %0d expected 4", byte_count); end
    #2;
    ioctl_download = 1'b0;
    mem_ready = 4'hF;
    reset = 1'b0;
    #1;
    tests_run++; if (mem_we !== 4'h0) begin tests_failed++; $display("FAIL rmid_mem_we: got %b expected 0", mem_we); end
    tests_run++; if (mem_addr !== 16'h0 || mem_data !== 8'h0) begin tests_failed++; $display("FAIL rmid_mem_bus: got addr=%h data=%h expected 0", mem_addr, mem_data); end
    tests_run++; if (byte_count !== 25'd0) begin tests_failed++; $display("FAIL rmid_byte_count: got %0d expected 0", byte_count); end
    tests_run++; if (ioctl_wait !== 1'b0 || done !== 4'h0) begin tests_failed++; $display("FAIL rmid_wait_done: got wait=%b done=%b expected 0", ioctl_wait, done); end
    step(); step();
    reset = 1'b1;
    repeat (10) step();
    tests_run++; if (log_we.size() !== 0) begin tests_failed++; $display("FAIL rmid_no_writes: got %0d expected 0", log_we.size()); end
    tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL rmid_no_done: got %0d expected 0", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_overflow();
    test_range();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
